mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl.sv | 125 ++++++++++++
 tb/tb_mem_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates instruction fetch and load/store traffic onto a byte-wide synchronous RAM port
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        has_misbranch,
  input  logic        if_ask,
  input  logic [31:0] if_addr,
  output logic [31:0] if_inst,
  output logic        if_ready,
  input  logic        ls_ask,
  input  logic        ls_wr,
  input  logic [31:0] ls_addr,
  input  logic [1:0]  ls_size,
  input  logic [31:0] ls_wdata,
  output logic [31:0] ls_rdata,
  output logic        ls_ready,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);
  typedef enum logic [1:0] {IDLE, IF_RD, LS_RD, LS_WR} state_t;
  state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d, len;
  logic if_pend_q, if_pend_d, ls_pend_q, ls_pend_d, ls_wr_q;
  logic [1:0] ls_size_q;
  logic [31:0] if_addr_q, ls_addr_q, ls_wdata_q;
  logic [31:0] mem_a_q, mem_a_d, if_inst_q, if_inst_d, ls_rdata_q, ls_rdata_d, buf_q, buf_d;
  logic [7:0] mem_dout_q, mem_dout_d, ls_wd, wd_sh;
  logic mem_wr_q, mem_wr_d, if_ready_q, if_ready_d, ls_ready_q, ls_ready_d, cap_q, cap_d;
  logic if_acc, ls_acc, if_av, ls_av, ls_w, ls_blk, sel_ls, sel_if, idle, rd, last, abort, more, cap_en;
  logic [31:0] if_a, ls_a;
  assign if_acc = if_ask & ~has_misbranch;
  assign ls_acc = ls_ask & (ls_wr | ~has_misbranch);
  assign if_av = (if_pend_q & ~has_misbranch) | if_acc;
  assign ls_av = (ls_pend_q & (ls_wr_q | ~has_misbranch)) | ls_acc;
  assign if_a = if_pend_q ? if_addr_q : if_addr;
  assign ls_a = ls_pend_q ? ls_addr_q : ls_addr;
  assign ls_w = ls_pend_q ? ls_wr_q : ls_wr;
  assign ls_wd = ls_pend_q ? ls_wdata_q[7:0] : ls_wdata[7:0];
  assign ls_blk = ls_w & (ls_a[17:16] == 2'b11) & io_buffer_full;
  assign idle = state_q == IDLE;
  assign sel_ls = idle & ls_av & ~ls_blk;
  assign sel_if = idle & if_av & ~sel_ls;
  assign rd = state_q == IF_RD || state_q == LS_RD;
  assign len = state_q == IF_RD ? 3'd4 : {1'b0, ls_size_q} + 3'd1;
  assign last = ~idle & cnt_q == len;
  assign abort = rd & has_misbranch;
  assign more = ~idle & cnt_q + 3'd1 < len;
  assign cap_en = rd & cnt_q != 3'd0;
  assign wd_sh = 8'(ls_wdata_q >> {cnt_q + 3'd1, 3'b000});
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else if (rdy) state_q <= state_d;
  always_comb
    state_d = idle ? (sel_ls ? (ls_w ? LS_WR : LS_RD) : sel_if ? IF_RD : IDLE) : (last | abort) ? IDLE : state_q;
  // A byte arriving while rdy is low is grabbed once so the RAM re-reading a newer address cannot corrupt it
  always_comb begin
    cnt_d = (idle | state_d == IDLE) ? 3'd0 : cnt_q + 3'd1;
    mem_a_d = sel_ls ? ls_a : sel_if ? if_a : more ? mem_a_q + 32'd1 : mem_a_q;
    mem_wr_d = sel_ls ? ls_w : state_q == LS_WR & more;
    mem_dout_d = sel_ls & ls_w ? ls_wd : state_q == LS_WR & more ? wd_sh : mem_dout_q;
    buf_d = cap_en & ~cap_q ? buf_q | ({24'd0, mem_din} << {cnt_q - 3'd1, 3'b000}) : idle ? 32'd0 : buf_q;
    cap_d = ~rdy & (cap_q | cap_en);
    if_ready_d = state_q == IF_RD & last & ~abort;
    ls_ready_d = state_q == LS_WR & last | state_q == LS_RD & last & ~abort;
    if_inst_d = if_ready_d ? buf_d : if_inst_q;
    ls_rdata_d = state_q == LS_RD & last & ~abort ? buf_d : ls_rdata_q;
    if_pend_d = if_av & ~sel_if;
    ls_pend_d = ls_av & ~sel_ls;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt_q <= '0;
      if_pend_q <= 1'b0;
      ls_pend_q <= 1'b0;
      if_addr_q <= '0;
      ls_addr_q <= '0;
      ls_wdata_q <= '0;
      ls_wr_q <= 1'b0;
      ls_size_q <= '0;
      mem_a_q <= '0;
      mem_wr_q <= 1'b0;
      mem_dout_q <= '0;
      if_ready_q <= 1'b0;
      ls_ready_q <= 1'b0;
      if_inst_q <= '0;
      ls_rdata_q <= '0;
    end else if (rdy) begin
      cnt_q <= cnt_d;
      if_pend_q <= if_pend_d;
      ls_pend_q <= ls_pend_d;
      if (if_acc) if_addr_q <= if_addr;
      if (ls_acc) begin
        ls_addr_q <= ls_addr;
        ls_wdata_q <= ls_wdata;
        ls_wr_q <= ls_wr;
        ls_size_q <= ls_size;
      end
      mem_a_q <= mem_a_d;
      mem_wr_q <= mem_wr_d;
      mem_dout_q <= mem_dout_d;
      if_ready_q <= if_ready_d;
      ls_ready_q <= ls_ready_d;
      if_inst_q <= if_inst_d;
      ls_rdata_q <= ls_rdata_d;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      buf_q <= '0;
      cap_q <= 1'b0;
    end else begin
      buf_q <= buf_d;
      cap_q <= cap_d;
    end
  assign if_ready = if_ready_q & rdy;
  assign ls_ready = ls_ready_q & rdy;
  assign mem_wr = mem_wr_q & rdy;
  assign mem_a = mem_a_q;
  assign mem_dout = mem_dout_q;
  assign if_inst = if_inst_q;
  assign ls_rdata = ls_rdata_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed and random transactions against a byte-array memory model
module tb_mem_ctrl;
  logic clk = 0, rst = 1, rdy = 1, has_misbranch = 0, if_ask = 0, ls_ask = 0, ls_wr = 0, io_buffer_full = 0;
  logic [31:0] if_addr = 0, ls_addr = 0, ls_wdata = 0;
  logic [1:0] ls_size = 0;
  logic [31:0] if_inst, ls_rdata, mem_a;
  logic if_ready, ls_ready, mem_wr;
  logic [7:0] mem_din, mem_dout;
  logic [7:0] ram [0:262143];
  logic [7:0] ref_mem [0:262143];
  logic ram_init = 1;
  int salt;
  logic [39:0] wq [$];
  int n_chk = 0, n_fail = 0;

  mem_ctrl dut (.clk(clk), .rst(rst), .rdy(rdy), .has_misbranch(has_misbranch), .if_ask(if_ask),
    .if_addr(if_addr), .if_inst(if_inst), .if_ready(if_ready), .ls_ask(ls_ask), .ls_wr(ls_wr),
    .ls_addr(ls_addr), .ls_size(ls_size), .ls_wdata(ls_wdata), .ls_rdata(ls_rdata), .ls_ready(ls_ready),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full));

  always #5 clk = ~clk;

  function automatic logic [7:0] pat(int i, int s);
    case (i)
      32'h100: return 8'h13;
      32'h101: return 8'h05;
      32'h102, 32'h103: return 8'h00;
      default: return 8'(((i ^ s) * 32'd2654435761) >> 24);
    endcase
  endfunction

  always @(posedge clk)
    if (ram_init) for (int i = 0; i < 262144; i++) ram[i] <= pat(i, salt);
    else begin
      if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
      mem_din <= ram[mem_a[17:0]];
    end

  always @(negedge clk) if (mem_wr) wq.push_back({mem_a, mem_dout});

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_rd(logic [31:0] a, int n);
    logic [31:0] r = 0;
    for (int i = 0; i < n; i++) r |= 32'(ref_mem[18'(a + 32'(i))]) << (8 * i);
    return r;
  endfunction

  task automatic do_tx(input int kind, input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd,
                       output int lat, output logic [31:0] data);
    @(negedge clk);
    if (kind == 0) begin if_ask = 1; if_addr = a; end
    else begin ls_ask = 1; ls_wr = kind == 2; ls_addr = a; ls_size = sz; ls_wdata = wd; end
    lat = 0;
    do begin
      @(negedge clk);
      if_ask = 0;
      ls_ask = 0;
      lat++;
    end while (!(kind == 0 ? if_ready : ls_ready) && lat < 40);
    data = kind == 0 ? if_inst : ls_rdata;
  endtask

  task automatic run_tx(input string tag, input int kind, input logic [31:0] a, input logic [1:0] sz,
                        input logic [31:0] wd, input int extra);
    int n = kind == 0 ? 4 : int'(sz) + 1;
    int base = wq.size();
    int lat;
    logic [31:0] d;
    do_tx(kind, a, sz, wd, lat, d);
    chk({tag, "_lat"}, 64'(lat), 64'(n + 2 + extra));
    if (kind == 2) begin
      chk({tag, "_nwr"}, 64'(wq.size() - base), 64'(n));
      for (int i = 0; i < n; i++) begin
        chk({tag, "_wr"}, base + i < wq.size() ? wq[base + i] : 40'hx, {a + 32'(i), 8'(wd >> (8 * i))});
        ref_mem[18'(a + 32'(i))] = 8'(wd >> (8 * i));
      end
    end else chk({tag, "_data"}, d, ref_rd(a, n));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ls_at, if_at, n_lr, n_ir, base, kind, r;
    logic [31:0] d_ls, d_if, wd, a;
    salt = $urandom;
    for (int i = 0; i < 262144; i++) ref_mem[i] = pat(i, salt);
    repeat (2) @(negedge clk);
    chk("rst_if_ready", if_ready, 0);
    chk("rst_ls_ready", ls_ready, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_mem_a", mem_a, 0);
    chk("rst_mem_dout", mem_dout, 0);
    chk("rst_if_inst", if_inst, 0);
    chk("rst_ls_rdata", ls_rdata, 0);
    ram_init = 0;
    rst = 0;
    @(negedge clk);
    if_ask = 1;
    if_addr = 32'h100;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if_ask = 0;
      if (c <= 4) chk("if_mem_a", mem_a, 32'h100 + 32'(c) - 1);
      chk("if_ready_cycle", if_ready, c == 6);
      if (c == 6) chk("if_inst", if_inst, 32'h00000513);
    end
    @(negedge clk);
    if_ask = 1; if_addr = 32'h104;
    ls_ask = 1; ls_wr = 0; ls_addr = 32'h200; ls_size = 0;
    ls_at = 0; if_at = 0; n_lr = 0; n_ir = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if_ask = 0;
      ls_ask = 0;
      if (ls_ready) begin n_lr++; if (ls_at == 0) begin ls_at = c; d_ls = ls_rdata; end end
      if (if_ready) begin n_ir++; if (if_at == 0) begin if_at = c; d_if = if_inst; end end
    end
    chk("prio_ls_at", 64'(ls_at), 3);
    chk("prio_if_at", 64'(if_at), 9);
    chk("prio_ls_pulses", 64'(n_lr), 1);
    chk("prio_if_pulses", 64'(n_ir), 1);
    chk("prio_ls_data", d_ls, ref_rd(32'h200, 1));
    chk("prio_if_data", d_if, ref_rd(32'h104, 4));
    run_tx("st", 2, 32'h40, 2'd3, 32'hDEADBEEF, 0);
    run_tx("st_rb", 1, 32'h40, 2'd3, 0, 0);
    base = wq.size();
    wd = $urandom;
    @(negedge clk);
    if_ask = 1; if_addr = 32'h500;
    @(negedge clk);
    if_ask = 0;
    ls_ask = 1; ls_wr = 1; ls_addr = 32'h600; ls_size = 1; ls_wdata = wd;
    @(negedge clk);
    ls_ask = 0;
    has_misbranch = 1;
    n_lr = 0; n_ir = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      has_misbranch = 0;
      n_ir += int'(if_ready);
      n_lr += int'(ls_ready);
    end
    chk("flush_if_ready", 64'(n_ir), 0);
    chk("flush_ls_ready", 64'(n_lr), 1);
    chk("flush_nwr", 64'(wq.size() - base), 2);
    for (int i = 0; i < 2; i++) begin
      chk("flush_wr", base + i < wq.size() ? wq[base + i] : 40'hx, {32'h600 + 32'(i), 8'(wd >> (8 * i))});
      ref_mem[18'(32'h600 + 32'(i))] = 8'(wd >> (8 * i));
    end
    io_buffer_full = 1;
    base = wq.size();
    @(negedge clk);
    if_ask = 1; if_addr = 32'h700;
    ls_ask = 1; ls_wr = 1; ls_addr = 32'h30000; ls_size = 0; ls_wdata = 32'h5A;
    n_lr = 0; n_ir = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if_ask = 0;
      ls_ask = 0;
      if (if_ready) begin n_ir++; d_if = if_inst; end
      n_lr += int'(ls_ready);
    end
    chk("io_if_ready", 64'(n_ir), 1);
    chk("io_if_data", d_if, ref_rd(32'h700, 4));
    chk("io_ls_held", 64'(n_lr), 0);
    chk("io_no_wr", 64'(wq.size() - base), 0);
    io_buffer_full = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_lr += int'(ls_ready);
    end
    chk("io_ls_ready", 64'(n_lr), 1);
    chk("io_nwr", 64'(wq.size() - base), 1);
    chk("io_wr", wq.size() > base ? wq[base] : 40'hx, {32'h30000, 8'h5A});
    ref_mem[18'h30000] = 8'h5A;
    fork
      run_tx("rdy", 1, 32'h300, 2'd3, 0, 3);
      begin
        repeat (3) @(negedge clk);
        rdy = 0;
        repeat (3) @(negedge clk);
        rdy = 1;
      end
    join
    wd = $urandom;
    @(negedge clk);
    ls_ask = 1; ls_wr = 1; ls_addr = 32'h80; ls_size = 3; ls_wdata = wd;
    @(negedge clk);
    ls_ask = 0;
    @(negedge clk);
    #2 rst = 1;
    base = wq.size();
    @(negedge clk);
    rst = 0;
    n_lr = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_lr += int'(ls_ready);
    end
    chk("rst_no_ready", 64'(n_lr), 0);
    chk("rst_no_wr", 64'(wq.size() - base), 0);
    ref_mem[18'h80] = wd[7:0];
    run_tx("rst_rb", 1, 32'h80, 2'd3, 0, 0);
    repeat (150) begin
      kind = $urandom_range(0, 2);
      r = $urandom_range(0, 2);
      a = $urandom_range(0, 32'hFFF0);
      run_tx("rnd", kind, a, r == 2 ? 2'd3 : 2'(r), $urandom, 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
